sc_node_arbiter: RTL

SC_NODE_ARBITER -- requirements
Module: sc_node_arbiter

---
 rtl/sc_arb_pkg.sv | 20 ++
 rtl/sc_rr_pick.sv | 36 +++
 rtl/sc_node_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sc_arb_pkg.sv
// Shared types and helpers for the source-channel node arbiter.
// Latency: n/a (types, constants and an elaboration-time function only).
// Backpressure: n/a.
package sc_arb_pkg;

    // Arbiter FSM: IDLE waits for a request; LOCKED forwards one packet from the owner.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Bit position of the last-beat flag inside a channel's info field.
    localparam int LAST_BIT = 0;

    // Width of an index into n sources; never less than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sc_rr_pick.sv
// Round-robin picker: first requesting index at or after ptr, wrapping N-1 -> 0.
// Latency: purely combinational.
// Backpressure: none; valid simply reports that some request is present.
// Ports: req[N] request vector, ptr start index -> winner index, valid.
module sc_rr_pick
    import sc_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        valid  = 1'b0;
        // Walk offsets from farthest to nearest so the nearest requester is the
        // last assignment and therefore wins.
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                winner = IDX_W'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sc_node_arbiter.sv
// Packet arbiter: NUM_SRC source channels onto one destination, round-robin, packet-locked.
// Latency: 1 cycle request->grant; data path combinational (+1 cycle with SC_NODE_ARBITER_OUTREG_EN).
// Backpressure: only the owner sees recv; it follows m_sc_recv (or skid-buffer not-full with the macro).
// Ports: sc_aclk/sc_aresetn; s_sc_req/send/info/payld in, s_sc_recv out per source;
//        m_sc_req/send/info/payld out, m_sc_recv in; grant_id/busy status.
// Config: define SC_NODE_ARBITER_OUTREG_EN to register the destination side through a 2-entry skid buffer.
module sc_node_arbiter
    import sc_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int PAYLD_W = 174,
    parameter int INFO_W  = 1
) (
    input  logic                         sc_aclk,
    input  logic                         sc_aresetn,
    input  logic [NUM_SRC-1:0]           s_sc_req,
    input  logic [NUM_SRC-1:0]           s_sc_send,
    output logic [NUM_SRC-1:0]           s_sc_recv,
    input  logic [NUM_SRC*INFO_W-1:0]    s_sc_info,
    input  logic [NUM_SRC*PAYLD_W-1:0]   s_sc_payld,
    output logic                         m_sc_req,
    output logic                         m_sc_send,
    input  logic                         m_sc_recv,
    output logic [INFO_W-1:0]            m_sc_info,
    output logic [PAYLD_W-1:0]           m_sc_payld,
    output logic [idx_w(NUM_SRC)-1:0]    grant_id,
    output logic                         busy
);

    localparam int IDX_W = idx_w(NUM_SRC);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;

    logic               locked;
    logic               src_send;
    logic               src_rdy;
    logic               last_xfer;
    logic [INFO_W-1:0]  src_info;
    logic [PAYLD_W-1:0] src_payld;

    sc_rr_pick #(
        .N     (NUM_SRC),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (s_sc_req),
        .ptr    (rr_ptr_q),
        .winner (pick_idx),
        .valid  (pick_vld)
    );

    assign locked    = (state_q == ST_LOCKED);
    assign src_send  = s_sc_send[grant_q];
    assign src_info  = s_sc_info[int'(grant_q)*INFO_W +: INFO_W];
    assign src_payld = s_sc_payld[int'(grant_q)*PAYLD_W +: PAYLD_W];
    assign s_sc_recv = locked ? (NUM_SRC'(src_rdy) << grant_q) : '0;
    // End of packet is judged where the owner's beat is accepted, so the next
    // grant can be taken on that same edge.
    assign last_xfer = locked & src_send & src_rdy & src_info[LAST_BIT];

    assign m_sc_req  = |s_sc_req;
    assign busy      = locked;
    assign grant_id  = grant_q;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d  = ST_LOCKED;
                    grant_d  = pick_idx;
                    rr_ptr_d = (pick_idx == IDX_W'(NUM_SRC - 1)) ? '0 : pick_idx + 1'b1;
                end
            end
            ST_LOCKED: begin
                // rr_ptr already sits one past the owner, so a re-request from
                // the owner is considered last.
                if (last_xfer) begin
                    if (pick_vld) begin
                        grant_d  = pick_idx;
                        rr_ptr_d = (pick_idx == IDX_W'(NUM_SRC - 1)) ? '0 : pick_idx + 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sc_aclk or negedge sc_aresetn) begin
        if (!sc_aresetn) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef SC_NODE_ARBITER_OUTREG_EN
    // Two-entry skid buffer: the owner is throttled by registered occupancy only,
    // so two slots sustain one beat per cycle while m_sc_recv stays high.
    localparam int ENT_W = INFO_W + PAYLD_W;

    logic [1:0]            cnt_q, cnt_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0][ENT_W-1:0] mem_q, mem_d;
    logic                  push;
    logic                  pop;

    assign src_rdy = (cnt_q != 2'd2);
    assign push    = locked & src_send & src_rdy;
    assign pop     = (cnt_q != 2'd0) & m_sc_recv;

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = {src_info, src_payld};
        end
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge sc_aclk or negedge sc_aresetn) begin
        if (!sc_aresetn) begin
            cnt_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    // Buffered beats still drain after the FSM has returned to IDLE.
    assign m_sc_send               = (cnt_q != 2'd0);
    assign {m_sc_info, m_sc_payld} = (cnt_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
`else
    assign src_rdy    = m_sc_recv;
    assign m_sc_send  = locked & src_send;
    assign m_sc_info  = locked ? src_info  : '0;
    assign m_sc_payld = locked ? src_payld : '0;
`endif

endmodule
